// File: rtl/iob_cache_fe_arbiter.sv
// iob_cache_fe_arbiter
//
// Purpose: shares the single IOb native front-end port of an iob_cache among
// N_MASTERS IOb native requesters. One requester is granted at a time. The
// grant is held until the cache acknowledges. The acknowledge is routed back
// to the granted requester, and then a new winner is chosen. Selection is
// round-robin (ARB_POL = 0) or fixed priority, where the lowest index wins
// (ARB_POL = 1).
//
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   m_req     per-requester request, held high until the matching m_ack
//   m_addr    per-requester word address (slice i = requester i)
//   m_wdata   per-requester write data
//   m_wstrb   per-requester byte strobes (all zero = read)
//   m_rdata   s_rdata replicated to every requester slice
//   m_ack     one-hot acknowledge, only ever for the granted requester
//   s_req     request to the cache front-end
//   s_addr    address of the granted requester (zero while idle)
//   s_wdata   write data of the granted requester (zero while idle)
//   s_wstrb   strobes of the granted requester (zero while idle)
//   s_rdata   cache read data, valid with s_ack
//   s_ack     cache acknowledge, one-cycle pulse
//   busy      high while a grant is held
//   grant     index of the current or most recent grant
module iob_cache_fe_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int ARB_POL   = 0,
  parameter int GNT_W     = $clog2(N_MASTERS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_MASTERS-1:0]              m_req,
  input  logic [N_MASTERS*ADDR_W-1:0]       m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]       m_wdata,
  input  logic [N_MASTERS*(DATA_W/8)-1:0]   m_wstrb,
  output logic [N_MASTERS*DATA_W-1:0]       m_rdata,
  output logic [N_MASTERS-1:0]              m_ack,
  output logic                              s_req,
  output logic [ADDR_W-1:0]                 s_addr,
  output logic [DATA_W-1:0]                 s_wdata,
  output logic [DATA_W/8-1:0]               s_wstrb,
  input  logic [DATA_W-1:0]                 s_rdata,
  input  logic                              s_ack,
  output logic                              busy,
  output logic [GNT_W-1:0]                  grant
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // After reset the "previous" winner is the highest index, so the
  // round-robin search starts at requester 0.
  localparam logic [GNT_W-1:0] LAST_RST = GNT_W'(N_MASTERS - 1);

  state_t           state_q, state_d;
  logic [GNT_W-1:0] grant_q, grant_d;
  logic [GNT_W-1:0] last_q, last_d;

  logic [N_MASTERS-1:0] hi_mask;
  logic [N_MASTERS-1:0] masked_req;
  logic [GNT_W-1:0]     pick_hi;
  logic [GNT_W-1:0]     pick_all;
  logic [GNT_W-1:0]     winner;

  // Winner selection.
  // Round-robin: first look only at requesters above the last winner. If none
  // of them is requesting, wrap around and take the lowest set index overall.
  // Fixed priority: always take the lowest set index.
  // Both searches only visit indices below N_MASTERS. A non-power-of-two
  // configuration therefore never produces an out-of-range grant.
  always_comb begin
    hi_mask  = '0;
    pick_hi  = '0;
    pick_all = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      hi_mask[i] = (GNT_W'(i) > last_q);
    end
    masked_req = m_req & hi_mask;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (masked_req[i]) pick_hi = GNT_W'(i);
      if (m_req[i])      pick_all = GNT_W'(i);
    end
    if ((ARB_POL == 0) && (|masked_req)) winner = pick_hi;
    else                                 winner = pick_all;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic.
  // s_ack is ignored in IDLE, so a late acknowledge for a transaction that
  // was aborted by reset is silently dropped. In BUSY the arbiter waits for
  // s_ack even if the granted requester drops m_req early.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|m_req) begin
          state_d = BUSY;
          grant_d = winner;
        end
      end
      BUSY: begin
        if (s_ack) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  // The granted slice is selected by comparing grant_q against each index,
  // which keeps every select index a constant. The ack path is purely
  // combinational from s_ack.
  always_comb begin
    busy    = (state_q == BUSY);
    grant   = grant_q;
    s_req   = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    m_ack   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if ((state_q == BUSY) && (grant_q == GNT_W'(i))) begin
        s_req    = m_req[i];
        s_addr   = m_addr[i*ADDR_W +: ADDR_W];
        s_wdata  = m_wdata[i*DATA_W +: DATA_W];
        s_wstrb  = m_wstrb[i*(DATA_W/8) +: (DATA_W/8)];
        m_ack[i] = s_ack;
      end
    end
    m_rdata = {N_MASTERS{s_rdata}};
  end

endmodule

// File: tb/tb_iob_cache_fe_arbiter.sv
`timescale 1ns/1ps
// Testbench for iob_cache_fe_arbiter.
// Two instances with three requesters each: index 0 uses round-robin and
// index 1 uses fixed priority. The bench plays both the requesters and the
// cache. Expected transactions (winner index, routed address/data/strobes and
// the read data the cache returns) are queued when requests are raised. They
// are popped and compared when the arbiter presents them to the cache.
module tb_iob_cache_fe_arbiter;

  localparam int N  = 3;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int GW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  logic            rst;
  logic [N-1:0]    m_req_a   [2];
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*NB-1:0] m_wstrb;
  logic [N*DW-1:0] m_rdata_a [2];
  logic [N-1:0]    m_ack_a   [2];
  logic            s_req_a   [2];
  logic [AW-1:0]   s_addr_a  [2];
  logic [DW-1:0]   s_wdata_a [2];
  logic [NB-1:0]   s_wstrb_a [2];
  logic [DW-1:0]   s_rdata;
  logic            s_ack_a   [2];
  logic            busy_a    [2];
  logic [GW-1:0]   grant_a   [2];

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_dut
      iob_cache_fe_arbiter #(
        .N_MASTERS(N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .ARB_POL  (g)
      ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req_a[g]),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_wstrb(m_wstrb),
        .m_rdata(m_rdata_a[g]),
        .m_ack  (m_ack_a[g]),
        .s_req  (s_req_a[g]),
        .s_addr (s_addr_a[g]),
        .s_wdata(s_wdata_a[g]),
        .s_wstrb(s_wstrb_a[g]),
        .s_rdata(s_rdata),
        .s_ack  (s_ack_a[g]),
        .busy   (busy_a[g]),
        .grant  (grant_a[g])
      );
    end
  endgenerate

  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [NB-1:0] wstrb;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t          sb[$];
  logic [AW-1:0] reqAddr  [N];
  logic [DW-1:0] reqWdata [N];
  logic [NB-1:0] reqWstrb [N];

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int i, input logic [AW-1:0] a,
                               input logic [DW-1:0] wd, input logic [NB-1:0] ws);
    reqAddr[i]  = a;
    reqWdata[i] = wd;
    reqWstrb[i] = ws;
    m_addr[i*AW +: AW]  = a;
    m_wdata[i*DW +: DW] = wd;
    m_wstrb[i*NB +: NB] = ws;
  endtask

  task automatic pushTxn(input int idx, input logic [DW-1:0] rd);
    txn_t e;
    e.idx   = idx;
    e.addr  = reqAddr[idx];
    e.wdata = reqWdata[idx];
    e.wstrb = reqWstrb[idx];
    e.rdata = rd;
    sb.push_back(e);
  endtask

  // Cache model for one transaction on instance gi.
  // It waits (bounded) for s_req, compares the routed request with the
  // scoreboard head, acknowledges 'lat' cycles after s_req first appears, and
  // checks the acknowledge routing. It returns at the drive point of the
  // bubble cycle that follows the acknowledge.
  task automatic serveTxn(input int gi, input int lat, output int rise);
    txn_t         e;
    int           waited;
    logic [N-1:0] oh;
    waited = 0;
    rise   = -1;
    @(negedge clk);
    while (s_req_a[gi] !== 1'b1 && waited < 20) begin
      cyc();
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      checkOutput($sformatf("s_req_timeout_g%0d", gi), 64'(s_req_a[gi]), 64'd1);
      return;
    end
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty g%0d observed=request expected=none", gi);
      return;
    end
    e    = sb.pop_front();
    rise = cycleCnt;
    checkOutput($sformatf("grant_g%0d", gi), 64'(grant_a[gi]), 64'(e.idx));
    checkOutput($sformatf("s_addr_g%0d", gi), 64'(s_addr_a[gi]), 64'(e.addr));
    checkOutput($sformatf("s_wdata_g%0d", gi), 64'(s_wdata_a[gi]), 64'(e.wdata));
    checkOutput($sformatf("s_wstrb_g%0d", gi), 64'(s_wstrb_a[gi]), 64'(e.wstrb));
    checkOutput($sformatf("busy_g%0d", gi), 64'(busy_a[gi]), 64'd1);
    checkOutput($sformatf("m_ack_early_g%0d", gi), 64'(m_ack_a[gi]), 64'd0);
    for (int k = 1; k < lat; k++) begin
      cyc();
      @(negedge clk);
      checkOutput($sformatf("s_req_hold_g%0d", gi), 64'(s_req_a[gi]), 64'd1);
      checkOutput($sformatf("m_ack_wait_g%0d", gi), 64'(m_ack_a[gi]), 64'd0);
    end
    cyc();
    s_ack_a[gi] = 1'b1;
    s_rdata     = e.rdata;
    @(negedge clk);
    oh        = '0;
    oh[e.idx] = 1'b1;
    checkOutput($sformatf("m_ack_g%0d", gi), 64'(m_ack_a[gi]), 64'(oh));
    checkOutput($sformatf("m_rdata_g%0d", gi), 64'(m_rdata_a[gi][e.idx*DW +: DW]), 64'(e.rdata));
    checkOutput($sformatf("m_rdata_rep_g%0d", gi),
                64'(m_rdata_a[gi][((e.idx + 1) % N)*DW +: DW]), 64'(e.rdata));
    cyc();
    s_ack_a[gi] = 1'b0;
    s_rdata     = 32'h0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rise;
    int prev;
    int t;
    rst        = 1'b1;
    m_req_a[0] = '0;
    m_req_a[1] = '0;
    s_ack_a[0] = 1'b0;
    s_ack_a[1] = 1'b0;
    s_rdata    = '0;
    m_addr     = '0;
    m_wdata    = '0;
    m_wstrb    = '0;
    for (int i = 0; i < N; i++) applyStimulus(i, AW'(30'h200 + i * 16), 32'h1111_0000 + i, 4'b0000);

    // Reset state: outputs must be zero even though the bus carries data.
    cyc();
    cyc();
    @(negedge clk);
    for (int gi = 0; gi < 2; gi++) begin
      checkOutput($sformatf("rst_busy_g%0d", gi), 64'(busy_a[gi]), 64'd0);
      checkOutput($sformatf("rst_grant_g%0d", gi), 64'(grant_a[gi]), 64'd0);
      checkOutput($sformatf("rst_s_req_g%0d", gi), 64'(s_req_a[gi]), 64'd0);
      checkOutput($sformatf("rst_s_addr_g%0d", gi), 64'(s_addr_a[gi]), 64'd0);
      checkOutput($sformatf("rst_s_wdata_g%0d", gi), 64'(s_wdata_a[gi]), 64'd0);
      checkOutput($sformatf("rst_m_ack_g%0d", gi), 64'(m_ack_a[gi]), 64'd0);
    end
    cyc();
    rst = 1'b0;

    // Single read: s_req one cycle after m_req, ack 3 cycles later.
    applyStimulus(0, 30'h100, 32'h0, 4'b0000);
    pushTxn(0, 32'hDEAD_BEEF);
    cyc();
    m_req_a[0] = 3'b001;
    @(negedge clk);
    t = cycleCnt;
    checkOutput("single_s_req_idle", 64'(s_req_a[0]), 64'd0);
    serveTxn(0, 3, rise);
    checkOutput("single_latency", 64'(rise - t), 64'd1);
    m_req_a[0] = 3'b000;
    @(negedge clk);
    checkOutput("single_busy_after", 64'(busy_a[0]), 64'd0);
    checkOutput("single_m_ack_after", 64'(m_ack_a[0]), 64'd0);
    checkOutput("single_s_addr_after", 64'(s_addr_a[0]), 64'd0);

    // Write routing from requester 1 while requester 0 is idle.
    applyStimulus(1, 30'h2A0, 32'hA5A5_A5A5, 4'b0011);
    pushTxn(1, 32'h0BAD_F00D);
    cyc();
    m_req_a[0] = 3'b010;
    serveTxn(0, 2, rise);
    m_req_a[0] = 3'b000;

    // Round-robin contention: 4 transactions each, ack latency 1.
    for (int n = 0; n < 8; n++) pushTxn(n % 2, 32'hC000_0000 + n);
    cyc();
    m_req_a[0] = 3'b011;
    prev = -1;
    for (int n = 0; n < 8; n++) begin
      serveTxn(0, 1, rise);
      if (n > 0) checkOutput($sformatf("rr_spacing_%0d", n), 64'(rise - prev), 64'd3);
      prev = rise;
      if (n == 6) m_req_a[0][0] = 1'b0;
      if (n == 7) m_req_a[0] = 3'b000;
    end

    // Wrap: grant 2, then 0 and 1.
    pushTxn(2, 32'h2222_2222);
    cyc();
    m_req_a[0] = 3'b100;
    serveTxn(0, 1, rise);
    pushTxn(0, 32'h3333_0000);
    pushTxn(1, 32'h3333_0001);
    m_req_a[0] = 3'b011;
    serveTxn(0, 1, rise);
    m_req_a[0] = 3'b010;
    serveTxn(0, 1, rise);
    m_req_a[0] = 3'b000;

    // Leave requester 0 as the last winner so that reset recovery differs.
    pushTxn(0, 32'h4444_4444);
    cyc();
    m_req_a[0] = 3'b001;
    serveTxn(0, 1, rise);
    m_req_a[0] = 3'b000;

    // Reset mid-operation with a late acknowledge.
    cyc();
    m_req_a[0] = 3'b010;
    cyc();
    @(negedge clk);
    checkOutput("rstop_s_req_busy", 64'(s_req_a[0]), 64'd1);
    checkOutput("rstop_grant_busy", 64'(grant_a[0]), 64'd1);
    cyc();
    rst = 1'b1;
    cyc();
    rst        = 1'b0;
    s_ack_a[0] = 1'b1;
    s_rdata    = 32'hFFFF_0000;
    m_req_a[0] = 3'b011;
    pushTxn(0, 32'h5555_0000);
    pushTxn(1, 32'h5555_0001);
    @(negedge clk);
    checkOutput("rstop_s_req", 64'(s_req_a[0]), 64'd0);
    checkOutput("rstop_m_ack", 64'(m_ack_a[0]), 64'd0);
    checkOutput("rstop_busy", 64'(busy_a[0]), 64'd0);
    checkOutput("rstop_grant", 64'(grant_a[0]), 64'd0);
    cyc();
    s_ack_a[0] = 1'b0;
    s_rdata    = 32'h0;
    serveTxn(0, 2, rise);
    m_req_a[0] = 3'b010;
    serveTxn(0, 2, rise);
    m_req_a[0] = 3'b000;

    // Fixed priority: requester 2 starved while requester 1 requests.
    for (int n = 0; n < 3; n++) pushTxn(1, 32'h6666_0000 + n);
    cyc();
    m_req_a[1] = 3'b110;
    for (int n = 0; n < 3; n++) serveTxn(1, 1, rise);
    pushTxn(0, 32'h7777_0000);
    m_req_a[1] = 3'b111;
    serveTxn(1, 1, rise);
    pushTxn(1, 32'h7777_0001);
    m_req_a[1] = 3'b110;
    serveTxn(1, 1, rise);
    pushTxn(2, 32'h7777_0002);
    m_req_a[1] = 3'b100;
    serveTxn(1, 1, rise);
    m_req_a[1] = 3'b000;
    @(negedge clk);
    checkOutput("fp_busy_end", 64'(busy_a[1]), 64'd0);
    checkOutput("fp_grant_end", 64'(grant_a[1]), 64'd2);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
